// File: rtl/mdu_seq_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle multiply/divide unit.
`timescale 1ns/1ps
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mdu_op;
  logic             msub;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] A2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdu_op, msub, A1, A2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mdu_op, msub, A1, A2, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers: mult/multu/madd/msub in MUL_CYCLES,
// div/divu by radix-2 restoring division in WIDTH cycles, mthi/mtlo in a single cycle.
`timescale 1ns/1ps
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  mdu_seq_if.slave   bus
);

  localparam int MAXN = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_t;

  state_t           r_state;
  state_t           w_state_nx;
  op_t              w_op;
  op_t              r_op;
  logic             r_sub;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Divider state: dividend magnitude shifts out of r_quo while quotient bits shift in.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_finish;
  logic             w_div_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_rem_nx;
  logic             w_dz;

  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  assign w_op     = op_t'(bus.mdu_op);
  assign w_accept = bus.start && !bus.flush && (r_state == S_IDLE);

  // Operand conditioning at acceptance: signed divide works on magnitudes.
  assign w_div_signed = (w_op == OP_DIV);
  assign w_mag_a = (w_div_signed && bus.A1[WIDTH-1]) ? -bus.A1 : bus.A1;
  assign w_mag_b = (w_div_signed && bus.A2[WIDTH-1]) ? -bus.A2 : bus.A2;

  // One restoring-division step per cycle.
  assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_dvs};
  assign w_ge        = !w_diff[WIDTH];
  assign w_quo_nx    = {r_quo[WIDTH-2:0], w_ge};
  assign w_rem_nx    = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign w_dz        = (r_b == '0);

  // Multiplier works on latched operands only, so hi/lo never follow A1/A2 combinationally.
  assign w_mul_a   = {{WIDTH{(r_op != OP_MULTU) && r_a[WIDTH-1]}}, r_a};
  assign w_mul_b   = {{WIDTH{(r_op != OP_MULTU) && r_b[WIDTH-1]}}, r_b};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_hilo    = {r_hi, r_lo};
  assign w_mul_res = (r_op != OP_MADD) ? w_prod :
                     r_sub             ? (w_hilo - w_prod) : (w_hilo + w_prod);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    w_hi_res = w_mul_res[2*WIDTH-1:WIDTH];
    w_lo_res = w_mul_res[WIDTH-1:0];
    if (r_state == S_DIV) begin
      if (w_dz) begin
        w_hi_res = r_a;
        w_lo_res = '1;
      end else begin
        w_hi_res = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_lo_res = r_neg_q ? -w_quo_nx : w_quo_nx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_MULT, OP_MULTU, OP_MADD: w_state_nx = S_MUL;
            OP_DIV, OP_DIVU:            w_state_nx = S_DIV;
            default:                    w_state_nx = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_state_nx = S_IDLE;
          w_finish   = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // NOTE: every datapath register is a flop, so all of them, operand latches included, take the reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= OP_NONE;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        case (w_op)
          OP_MTHI: r_hi <= bus.A1;
          OP_MTLO: r_lo <= bus.A1;
          OP_MULT, OP_MULTU, OP_MADD: begin
            r_op  <= w_op;
            r_sub <= bus.msub;
            r_a   <= bus.A1;
            r_b   <= bus.A2;
            r_cnt <= CW'(MUL_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            r_op    <= w_op;
            r_a     <= bus.A1;
            r_b     <= bus.A2;
            r_quo   <= w_mag_a;
            r_rem   <= '0;
            r_dvs   <= w_mag_b;
            r_neg_q <= w_div_signed && (bus.A1[WIDTH-1] ^ bus.A2[WIDTH-1]);
            r_neg_r <= w_div_signed && bus.A1[WIDTH-1];
            r_cnt   <= CW'(WIDTH);
          end
          default: ;
        endcase
      end else if ((r_state != S_IDLE) && !bus.flush) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_state == S_DIV) begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
        end
        if (w_finish) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq (WIDTH=32, MUL_CYCLES=5) with hand-computed HI/LO results.
`timescale 1ns/1ps
module tb_mdu_seq;

  localparam int W  = 32;
  localparam int NM = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .MUL_CYCLES(NM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive a request before edge E0; return 1 time unit after E0 with operands scrambled.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ms);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A1     = a;
    bus.A2     = b;
    bus.msub   = ms;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    bus.A1     = $urandom;
    bus.A2     = $urandom;
    bus.msub   = ~ms;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ms, input int n, input bit poke,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int k;
    start_op(op, a, b, ms);
    if (n == 0) begin
      check({tag, ".busy"}, 64'(bus.busy), 64'(0));
      check({tag, ".done"}, 64'(bus.done), 64'(0));
    end else begin
      check({tag, ".busy0"}, 64'(bus.busy), 64'(1));
      k = 0;
      do begin
        if (poke && k == 1) begin
          bus.start  = 1'b1;
          bus.mdu_op = 3'd5;
          bus.A1     = 32'h0000_DEAD;
        end else if (poke && k == 2) begin
          bus.start  = 1'b0;
          bus.mdu_op = 3'd0;
        end
        @(posedge clk);
        #1;
        k++;
      end while (bus.busy && k < 100);
      check({tag, ".cycles"}, 64'(k), 64'(n));
      check({tag, ".done"}, 64'(bus.done), 64'(1));
      @(posedge clk);
      #1;
      check({tag, ".done_clr"}, 64'(bus.done), 64'(0));
    end
    check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_done;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    bus.msub   = 1'b0;
    bus.A1     = '0;
    bus.A2     = '0;
    bus.flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.done", 64'(bus.done), 64'(0));
    check("rst.hi", 64'(bus.hi), 64'(0));
    check("rst.lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    run_op("mult",   3'd1, 32'hFFFF_FFFD, 32'd7,        1'b0, NM, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu",  3'd2, 32'hFFFF_FFFF, 32'd2,        1'b0, NM, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("divu",   3'd4, 32'd100,       32'd7,        1'b0, W,  1'b0, 32'd2,         32'd14);
    run_op("div_n",  3'd3, 32'hFFFF_FFF9, 32'd2,        1'b0, W,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_d",  3'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, W, 1'b0, 32'd1,         32'hFFFF_FFFD);
    run_op("div_ov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, W, 1'b0, 32'd0,         32'h8000_0000);
    run_op("divu_z", 3'd4, 32'd5,         32'd0,        1'b0, W,  1'b0, 32'd5,         32'hFFFF_FFFF);
    run_op("div_z",  3'd3, 32'hFFFF_FFFB, 32'd0,        1'b0, W,  1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    run_op("mtlo",   3'd6, 32'd0,         32'd0,        1'b0, 0,  1'b0, 32'hFFFF_FFFB, 32'd0);
    run_op("mthi",   3'd5, 32'h0000_1234, 32'd0,        1'b0, 0,  1'b0, 32'h0000_1234, 32'd0);
    run_op("madd",   3'd7, 32'd2,         32'd3,        1'b0, NM, 1'b1, 32'h0000_1234, 32'd6);
    run_op("msub",   3'd7, 32'd1,         32'd1,        1'b1, NM, 1'b0, 32'h0000_1234, 32'd5);
    run_op("madd_n", 3'd7, 32'hFFFF_FFFE, 32'd3,        1'b0, NM, 1'b0, 32'h0000_1233, 32'hFFFF_FFFF);

    // Flush in the middle of a divide: no done, HI/LO keep their pre-op values.
    run_op("mthi2",  3'd5, 32'h0000_AAAA, 32'd0,        1'b0, 0,  1'b0, 32'h0000_AAAA, 32'hFFFF_FFFF);
    run_op("mtlo2",  3'd6, 32'h0000_5555, 32'd0,        1'b0, 0,  1'b0, 32'h0000_AAAA, 32'h0000_5555);
    start_op(3'd4, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("fl_div.busy", 64'(bus.busy), 64'(0));
    check("fl_div.done", 64'(bus.done), 64'(0));
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("fl_div.no_done", 64'(seen_done), 64'(0));
    check("fl_div.hi", 64'(bus.hi), 64'h0000_AAAA);
    check("fl_div.lo", 64'(bus.lo), 64'h0000_5555);

    // Flush on the completion edge of a multiply cancels the write-back.
    start_op(3'd1, 32'd5, 32'd5, 1'b0);
    repeat (NM - 1) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("fl_end.busy", 64'(bus.busy), 64'(0));
    check("fl_end.done", 64'(bus.done), 64'(0));
    check("fl_end.lo", 64'(bus.lo), 64'h0000_5555);

    // Flush overrides a simultaneous start in IDLE.
    @(negedge clk);
    bus.flush  = 1'b1;
    bus.start  = 1'b1;
    bus.mdu_op = 3'd5;
    bus.A1     = 32'd1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("fl_start.busy", 64'(bus.busy), 64'(0));
    check("fl_start.hi", 64'(bus.hi), 64'h0000_AAAA);

    // Back-to-back multiplies, then asynchronous reset during the second one.
    run_op("mult2",  3'd1, 32'd3,         32'd4,        1'b0, NM, 1'b0, 32'd0,         32'd12);
    start_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst.busy", 64'(bus.busy), 64'(0));
    check("arst.done", 64'(bus.done), 64'(0));
    check("arst.hi", 64'(bus.hi), 64'(0));
    check("arst.lo", 64'(bus.lo), 64'(0));
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
